// File: rtl/gps_ack_pkg.sv
// gps_ack_pkg: shared states, bin/record types and constants for the peak search.
// GPS_ACK_PEAK_SQUARE_EN selects the exact I^2+Q^2 magnitude (28-bit, one extra pipeline cycle).
package gps_ack_pkg;
    localparam int NCH       = 8;
    localparam int IW        = 14;
    localparam int PHASE_MOD = 1023;
`ifdef GPS_ACK_PEAK_SQUARE_EN
    localparam int MAG_LAT   = 1;
    localparam int MAG_W_DEF = 28;
`else
    localparam int MAG_LAT   = 0;
    localparam int MAG_W_DEF = 15;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_CAPTURE, S_ACCUM, S_REPORT, S_DONE
    } state_t;

    typedef struct packed {
        logic [9:0]  phase;
        logic [4:0]  frac;
        logic [15:0] doppler;
    } bin_t;

    typedef struct packed {
        logic [5:0]           sat;
        bin_t                 bin;
        logic [MAG_W_DEF-1:0] peak;
        logic [MAG_W_DEF-1:0] second;
        logic                 detect;
    } res_t;

    // Same Doppler and code phases within one chip, wrapping at the code length.
    function automatic logic adjacent(input bin_t a, input bin_t b);
        logic [9:0] a1, b1;
        a1 = (a.phase >= 10'(PHASE_MOD - 1)) ? 10'd0 : a.phase + 10'd1;
        b1 = (b.phase >= 10'(PHASE_MOD - 1)) ? 10'd0 : b.phase + 10'd1;
        return (a.doppler == b.doppler) && (a.phase == b.phase || a1 == b.phase || b1 == a.phase);
    endfunction
endpackage

// File: rtl/gps_ack_mag.sv
// gps_ack_mag: |I|,|Q| -> magnitude saturating to MAG_W; max+min/2 by default,
// exact I^2+Q^2 behind one register stage when GPS_ACK_PEAK_SQUARE_EN is defined.
module gps_ack_mag #(
    parameter int IW    = 14,
    parameter int MAG_W = 15
) (
`ifdef GPS_ACK_PEAK_SQUARE_EN
    input  logic                 clk,
    input  logic                 rst,
`endif
    input  logic signed [IW-1:0] i_i,
    input  logic signed [IW-1:0] q_i,
    output logic [MAG_W-1:0]     mag_o
);
    logic [IW-1:0] ai, aq;

    // Negating the most negative value wraps to the right unsigned magnitude.
    assign ai = i_i[IW-1] ? IW'(-i_i) : IW'(i_i);
    assign aq = q_i[IW-1] ? IW'(-q_i) : IW'(q_i);

`ifdef GPS_ACK_PEAK_SQUARE_EN
    localparam int SW = (2 * IW + 1 > MAG_W) ? 2 * IW + 1 : MAG_W;
    logic [2*IW-1:0] si_q, sq_q;
    logic [SW-1:0]   sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            si_q <= '0;
            sq_q <= '0;
        end else begin
            si_q <= (2 * IW)'(ai) * (2 * IW)'(ai);
            sq_q <= (2 * IW)'(aq) * (2 * IW)'(aq);
        end
    end

    assign sum = SW'(si_q) + SW'(sq_q);
`else
    localparam int SW = (IW + 1 > MAG_W) ? IW + 1 : MAG_W;
    logic [IW-1:0] mx, mn;
    logic [SW-1:0] sum;

    assign mx  = (ai > aq) ? ai : aq;
    assign mn  = (ai > aq) ? aq : ai;
    assign sum = SW'(mx) + SW'(mn >> 1);
`endif

    localparam logic [SW-1:0] SAT = SW'({MAG_W{1'b1}});

    assign mag_o = (sum > SAT) ? MAG_W'(SAT) : MAG_W'(sum);
endmodule

// File: rtl/gps_ack_peak.sv
// gps_ack_peak: per-channel peak/second-peak search over acquisition bins, then one
// detection record per active channel over valid/ready. Macro: GPS_ACK_PEAK_SQUARE_EN.
module gps_ack_peak
    import gps_ack_pkg::*;
#(
    parameter int NCH       = gps_ack_pkg::NCH,
    parameter int IW        = gps_ack_pkg::IW,
    parameter int THRESH_X8 = 20,
    parameter int MAG_W     = MAG_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                search_start,
    input  logic                corr_complete,
    input  logic                search_complete,
    input  logic [9:0]          code_phase,
    input  logic [4:0]          code_nco_frac,
    input  logic [15:0]         doppler_omega,
    input  logic [NCH*6-1:0]    sat,
    input  logic [NCH*IW-1:0]   integrator_i,
    input  logic [NCH*IW-1:0]   integrator_q,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [5:0]          res_sat,
    output logic [9:0]          res_code_phase,
    output logic [4:0]          res_code_frac,
    output logic [15:0]         res_doppler,
    output logic [MAG_W-1:0]    res_peak,
    output logic [MAG_W-1:0]    res_second,
    output logic                res_detect,
    output logic                busy,
    output logic                overrun
);
    localparam int KW = $clog2(NCH + 1);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW = MAG_W + 32;

    state_t               state_q, state_d;
    logic                 cc_q, sc_q, cc_rise_q, sc_rise_q;
    logic                 pend_q, pend_d, ovr_q, ovr_d, vld_q, vld_d;
    logic [KW-1:0]        k_q, k_d;
    res_t                 res_q, res_d;
    bin_t                 cap_bin_q;
    logic signed [IW-1:0] cap_i_q [NCH];
    logic signed [IW-1:0] cap_q_q [NCH];
    logic [MAG_W-1:0]     peak_q [NCH];
    logic [MAG_W-1:0]     sec_q [NCH];
    bin_t                 pbin_q [NCH];

    logic [CW-1:0]        ci, uc;
    logic [MAG_W-1:0]     mag, rpk, rsc;
    logic                 u_en, adj, take_pk, take_sec, det;
    logic [5:0]           rsat;

    // ci walks the channels; uc trails it by the magnitude unit latency.
    assign ci       = CW'(k_q);
    assign uc       = CW'(k_q - KW'(MAG_LAT));
    assign u_en     = (state_q == S_ACCUM) && (MAG_LAT == 0 || k_q != '0);
    assign adj      = adjacent(cap_bin_q, pbin_q[uc]);
    assign take_pk  = mag > peak_q[uc];
    assign take_sec = !adj && (mag > sec_q[uc]);
    assign rsat     = sat[ci*6 +: 6];
    assign rpk      = peak_q[ci];
    assign rsc      = sec_q[ci];
    assign det      = ((DW'(rpk) << 3) > DW'(rsc) * DW'(THRESH_X8)) && (rpk != '0);

    gps_ack_mag #(.IW(IW), .MAG_W(MAG_W)) u_mag (
`ifdef GPS_ACK_PEAK_SQUARE_EN
        .clk  (clk),
        .rst  (rst),
`endif
        .i_i  (cap_i_q[ci]),
        .q_i  (cap_q_q[ci]),
        .mag_o(mag)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cc_q      <= 1'b0;
            sc_q      <= 1'b0;
            cc_rise_q <= 1'b0;
            sc_rise_q <= 1'b0;
        end else begin
            cc_q      <= corr_complete;
            sc_q      <= search_complete;
            cc_rise_q <= corr_complete & ~cc_q;
            sc_rise_q <= search_complete & ~sc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        vld_d   = vld_q;
        k_d     = k_q;
        res_d   = res_q;
        if (search_start) begin
            state_d = S_COLLECT;
            pend_d  = 1'b0;
            ovr_d   = 1'b0;
            vld_d   = 1'b0;
            k_d     = '0;
            res_d   = '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (cc_rise_q) begin
                        state_d = S_CAPTURE;
                        pend_d  = sc_rise_q;
                    end else if (sc_rise_q) begin
                        state_d = S_REPORT;
                        k_d     = '0;
                    end
                end
                S_CAPTURE: begin
                    state_d = S_ACCUM;
                    k_d     = '0;
                    pend_d  = pend_q | sc_rise_q;
                    ovr_d   = ovr_q | cc_rise_q;
                end
                S_ACCUM: begin
                    pend_d = pend_q | sc_rise_q;
                    ovr_d  = ovr_q | cc_rise_q;
                    k_d    = k_q + 1'b1;
                    if (k_q == KW'(NCH - 1 + MAG_LAT)) begin
                        state_d = (pend_q || sc_rise_q) ? S_REPORT : S_COLLECT;
                        pend_d  = 1'b0;
                        k_d     = '0;
                    end
                end
                S_REPORT: begin
                    // The slot frees on acceptance; the next channel loads in the same edge.
                    if (!vld_q || res_ready) begin
                        if (k_q == KW'(NCH)) begin
                            state_d = S_DONE;
                            vld_d   = 1'b0;
                        end else begin
                            k_d   = k_q + 1'b1;
                            vld_d = rsat != 6'd0;
                            if (rsat != 6'd0)
                                res_d = '{sat: rsat, bin: pbin_q[ci], peak: MAG_W_DEF'(rpk),
                                          second: MAG_W_DEF'(rsc), detect: det};
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            vld_q   <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            vld_q   <= vld_d;
            k_q     <= k_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_bin_q <= '0;
            for (int j = 0; j < NCH; j++) begin
                cap_i_q[j] <= '0;
                cap_q_q[j] <= '0;
                peak_q[j]  <= '0;
                sec_q[j]   <= '0;
                pbin_q[j]  <= '0;
            end
        end else if (search_start) begin
            cap_bin_q <= '0;
            for (int j = 0; j < NCH; j++) begin
                cap_i_q[j] <= '0;
                cap_q_q[j] <= '0;
                peak_q[j]  <= '0;
                sec_q[j]   <= '0;
                pbin_q[j]  <= '0;
            end
        end else begin
            if (state_q == S_CAPTURE) begin
                cap_bin_q <= '{phase: code_phase, frac: code_nco_frac, doppler: doppler_omega};
                for (int j = 0; j < NCH; j++) begin
                    cap_i_q[j] <= integrator_i[j*IW +: IW];
                    cap_q_q[j] <= integrator_q[j*IW +: IW];
                end
            end
            // A new peak pushes the old one to second only when the bins are distinct.
            if (u_en && take_pk) begin
                if (!adj)
                    sec_q[uc] <= peak_q[uc];
                peak_q[uc] <= mag;
                pbin_q[uc] <= cap_bin_q;
            end else if (u_en && take_sec) begin
                sec_q[uc] <= mag;
            end
        end
    end

    assign res_valid      = vld_q;
    assign res_sat        = res_q.sat;
    assign res_code_phase = res_q.bin.phase;
    assign res_code_frac  = res_q.bin.frac;
    assign res_doppler    = res_q.bin.doppler;
    assign res_peak       = MAG_W'(res_q.peak);
    assign res_second     = MAG_W'(res_q.second);
    assign res_detect     = res_q.detect;
    assign busy           = !(state_q == S_IDLE || state_q == S_COLLECT);
    assign overrun        = ovr_q;
endmodule

// File: tb/tb_gps_ack_peak.sv
// tb_gps_ack_peak: directed bench for gps_ack_peak in its default (max + min/2) build.
module tb_gps_ack_peak;
    localparam int NCH = 8;
    localparam int IW  = 14;
    localparam int MW  = 15;

    logic              clk, rst, search_start, corr_complete, search_complete, res_ready;
    logic [9:0]        code_phase;
    logic [4:0]        code_nco_frac;
    logic [15:0]       doppler_omega;
    logic [NCH*6-1:0]  sat;
    logic [NCH*IW-1:0] integrator_i, integrator_q;
    logic              res_valid, res_detect, busy, overrun;
    logic [5:0]        res_sat;
    logic [9:0]        res_code_phase;
    logic [4:0]        res_code_frac;
    logic [15:0]       res_doppler;
    logic [MW-1:0]     res_peak, res_second;

    int total = 0;
    int bad = 0;
    int n;
    int r_sat [16];
    int r_ph [16];
    int r_frac [16];
    int r_dop [16];
    int r_pk [16];
    int r_sc [16];
    int r_det [16];
    int exp_prn [6] = '{1, 2, 3, 5, 7, 8};

    gps_ack_peak dut (
        .clk(clk), .rst(rst), .search_start(search_start), .corr_complete(corr_complete),
        .search_complete(search_complete), .code_phase(code_phase), .code_nco_frac(code_nco_frac),
        .doppler_omega(doppler_omega), .sat(sat), .integrator_i(integrator_i),
        .integrator_q(integrator_q), .res_valid(res_valid), .res_ready(res_ready),
        .res_sat(res_sat), .res_code_phase(res_code_phase), .res_code_frac(res_code_frac),
        .res_doppler(res_doppler), .res_peak(res_peak), .res_second(res_second),
        .res_detect(res_detect), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input int iv, input int qv);
        integrator_i[k*IW +: IW] = IW'(iv);
        integrator_q[k*IW +: IW] = IW'(qv);
    endtask

    task automatic clr_int();
        integrator_i = '0;
        integrator_q = '0;
    endtask

    task automatic start();
        search_start = 1'b1;
        @(negedge clk);
        search_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_bin(input int ph, input int dop);
        code_phase    = 10'(ph);
        code_nco_frac = 5'(ph);
        doppler_omega = 16'(dop);
        corr_complete = 1'b1;
        @(negedge clk);
        corr_complete = 1'b0;
        repeat (NCH + 4) @(negedge clk);
    endtask

    task automatic end_search();
        search_complete = 1'b1;
        @(negedge clk);
        search_complete = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!res_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk(tag, res_valid, 1);
    endtask

    task automatic collect();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (res_valid && res_ready && n < 16) begin
                r_sat[n] = res_sat; r_ph[n] = res_code_phase; r_frac[n] = res_code_frac;
                r_dop[n] = res_doppler; r_pk[n] = res_peak; r_sc[n] = res_second;
                r_det[n] = res_detect;
                n++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0; search_start = 1'b0; corr_complete = 1'b0; search_complete = 1'b0;
        res_ready = 1'b1; code_phase = '0; code_nco_frac = '0; doppler_omega = '0;
        clr_int();
        for (int k = 0; k < NCH; k++) sat[k*6 +: 6] = 6'(k + 1);
        #12;
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_peak", res_peak, 0);
        chk("rst_sat", res_sat, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single bin on ch0
        start();
        set_ch(0, 100, -40);
        do_bin(7, 5);
        end_search();
        collect();
        chk("s1_count", n, 8);
        chk("s1_sat0", r_sat[0], 1);
        chk("s1_peak0", r_pk[0], 120);
        chk("s1_second0", r_sc[0], 0);
        chk("s1_detect0", r_det[0], 1);
        chk("s1_phase0", r_ph[0], 7);
        chk("s1_frac0", r_frac[0], 7);
        chk("s1_dop0", r_dop[0], 5);
        chk("s1_peak1", r_pk[1], 0);
        chk("s1_detect1", r_det[1], 0);
        chk("s1_sat7", r_sat[7], 8);

        // adjacent-bin exclusion and ratio test
        start();
        clr_int(); set_ch(0, 200, 0); set_ch(1, 100, 0);
        do_bin(10, 5);
        clr_int(); set_ch(0, 180, 0);
        do_bin(11, 5);
        clr_int(); set_ch(0, 0, -60); set_ch(1, 50, 0);
        do_bin(500, 5);
        end_search();
        collect();
        chk("s2_count", n, 8);
        chk("s2_peak0", r_pk[0], 200);
        chk("s2_phase0", r_ph[0], 10);
        chk("s2_second0", r_sc[0], 60);
        chk("s2_detect0", r_det[0], 1);
        chk("s2_peak1", r_pk[1], 100);
        chk("s2_second1", r_sc[1], 50);
        chk("s2_detect1", r_det[1], 0);

        // phase wrap adjacency, tie, full-scale magnitude
        start();
        clr_int(); set_ch(0, 300, 0); set_ch(1, 0, 70); set_ch(3, -8192, -8192);
        do_bin(1022, -3);
        clr_int(); set_ch(0, 250, 0);
        do_bin(0, -3);
        clr_int(); set_ch(0, 90, 0); set_ch(1, -70, 0);
        do_bin(1, -3);
        end_search();
        collect();
        chk("s3_peak0", r_pk[0], 300);
        chk("s3_phase0", r_ph[0], 1022);
        chk("s3_second0", r_sc[0], 90);
        chk("s3_detect0", r_det[0], 1);
        chk("s3_dop0", r_dop[0], 16'hFFFD);
        chk("s3_peak1", r_pk[1], 70);
        chk("s3_phase1", r_ph[1], 1022);
        chk("s3_second1", r_sc[1], 70);
        chk("s3_detect1", r_det[1], 0);
        chk("s3_peak3", r_pk[3], 12288);
        chk("s3_detect3", r_det[3], 1);

        // unused channels skipped, record held under backpressure
        sat[3*6 +: 6] = 6'd0;
        sat[5*6 +: 6] = 6'd0;
        start();
        res_ready = 1'b0;
        end_search();
        wait_valid("s4_first_valid");
        chk("s4_first_sat", res_sat, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("s4_hold_valid", res_valid, 1);
            chk("s4_hold_sat", res_sat, 1);
            chk("s4_hold_phase", res_code_phase, 0);
        end
        res_ready = 1'b1;
        collect();
        chk("s4_count", n, 6);
        for (int i = 0; i < 6; i++) chk("s4_prn", r_sat[i], exp_prn[i]);
        for (int k = 0; k < NCH; k++) sat[k*6 +: 6] = 6'(k + 1);

        // overrun, search_complete during ACCUM, restart mid-report
        start();
        clr_int(); set_ch(0, 100, 0);
        code_phase = 10'd20; code_nco_frac = 5'd20; doppler_omega = 16'd7;
        corr_complete = 1'b1;
        @(negedge clk);
        corr_complete = 1'b0;
        @(negedge clk);
        @(negedge clk);
        set_ch(0, 500, 0); code_phase = 10'd600; corr_complete = 1'b1;
        @(negedge clk);
        corr_complete = 1'b0; search_complete = 1'b1;
        @(negedge clk);
        search_complete = 1'b0;
        chk("s5_overrun", overrun, 1);
        chk("s5_busy", busy, 1);
        chk("s5_no_early_valid", res_valid, 0);
        res_ready = 1'b0;
        wait_valid("s5_valid");
        chk("s5_peak0", res_peak, 100);
        chk("s5_phase0", res_code_phase, 20);
        search_start = 1'b1;
        @(negedge clk);
        search_start = 1'b0;
        chk("s5_restart_valid", res_valid, 0);
        chk("s5_restart_overrun", overrun, 0);
        chk("s5_restart_busy", busy, 0);
        res_ready = 1'b1;
        end_search();
        collect();
        chk("s5_count", n, 8);
        chk("s5_cleared_peak", r_pk[0], 0);
        chk("s5_cleared_phase", r_ph[0], 0);

        // async reset in ACCUM
        start();
        clr_int(); set_ch(0, 100, 0);
        corr_complete = 1'b1;
        @(negedge clk);
        corr_complete = 1'b0;
        @(negedge clk);
        @(negedge clk);
        corr_complete = 1'b1;
        @(negedge clk);
        corr_complete = 1'b0;
        @(negedge clk);
        chk("s6_busy_pre", busy, 1);
        chk("s6_overrun_pre", overrun, 1);
        #2 rst = 1'b0;
        #1;
        chk("s6_busy", busy, 0);
        chk("s6_overrun", overrun, 0);
        chk("s6_valid", res_valid, 0);
        chk("s6_peak", res_peak, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start();
        end_search();
        collect();
        chk("s6_count", n, 8);
        chk("s6_after_peak", r_pk[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
